// File: rtl/irq_dispatch_seq.sv
// ----------------------------------------------------------------------------
// irq_dispatch_seq
//
// Interrupt dispatch sequencer for an SM83-style CPU core. It samples the
// IE/IF registers at opcode-fetch points. When IME is set and an enabled flag
// is pending, it runs the dispatch sequence:
//   start (IDLE) -> WAIT0 -> WAIT1 -> PUSH_H -> PUSH_L -> JUMP
// The five M-cycles after the start cycle are two internal waits, the push of
// PC high, the push of PC low, and the vector load into PC.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cpu_en            M-cycle advance strobe; qualifies every state change and
//                     every strobe
//   instr_boundary    CPU is at an opcode fetch, so dispatch may start
//   ime, ie, if_in    interrupt master enable, enable register, flag register
//   pc                current PC value, pushed to the stack
//   busy              dispatch in progress; CPU suppresses fetch and pc_inc
//   ime_clear         clears IME, pulsed in the start cycle
//   halt_wake         some enabled interrupt is pending (ignores IME and reset)
//   sp_dec            SP decrement strobe
//   mem_write         stack write strobe, data in mem_wdata
//   pc_write          full PC load strobe, value in pc_wdata
//   if_clear          one-hot IF clear strobe for the serviced source
// ----------------------------------------------------------------------------
module irq_dispatch_seq #(
  parameter int unsigned NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_en,
  input  logic               instr_boundary,
  input  logic               ime,
  input  logic [NUM_IRQ-1:0] ie,
  input  logic [NUM_IRQ-1:0] if_in,
  input  logic [15:0]        pc,
  output logic               busy,
  output logic               ime_clear,
  output logic               halt_wake,
  output logic               sp_dec,
  output logic               mem_write,
  output logic [7:0]         mem_wdata,
  output logic               pc_write,
  output logic [15:0]        pc_wdata,
  output logic [NUM_IRQ-1:0] if_clear
);

  localparam int unsigned SelW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWait0,
    StWait1,
    StPushH,
    StPushL,
    StJump
  } state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              sel_valid_q;
  logic              reset_q;
  logic [NUM_IRQ-1:0] req;
  logic              pending;
  logic              act;
  logic              start;

  assign req       = ie & if_in;
  assign pending   = |req;
  assign halt_wake = pending;

  // reset_q keeps the block quiet for one cycle after reset is released.
  // Without it, a start could be taken in that cycle.
  assign act   = cpu_en & ~reset & ~reset_q;
  assign start = act & (state_q == StIdle) & instr_boundary & ime & pending;

  // Lowest set bit wins. The loop runs downward so the last match is the
  // lowest index.
  always_comb begin
    sel_d = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) sel_d = SelW'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the priority decision once, in PUSH_H. Later IE/IF changes
  // cannot redirect the jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
    end else if (act && state_q == StPushH) begin
      sel_q       <= sel_d;
      sel_valid_q <= pending;
    end
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (act) begin
      unique case (state_q)
        StIdle:  if (start) state_d = StWait0;
        StWait0: state_d = StWait1;
        StWait1: state_d = StPushH;
        StPushH: state_d = StPushL;
        StPushL: state_d = StJump;
        StJump:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode: Moore strobes gated by act. busy is a level and holds
  // through cpu_en gaps.
  always_comb begin
    busy      = ~reset & (start | (state_q != StIdle));
    ime_clear = 1'b0;
    sp_dec    = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    pc_write  = 1'b0;
    pc_wdata  = '0;
    if_clear  = '0;
    if (act) begin
      unique case (state_q)
        StIdle: ime_clear = start;
        StWait0: ;
        StWait1: sp_dec = 1'b1;
        StPushH: begin
          sp_dec    = 1'b1;
          mem_write = 1'b1;
          mem_wdata = pc[15:8];
        end
        StPushL: begin
          mem_write = 1'b1;
          mem_wdata = pc[7:0];
        end
        StJump: begin
          pc_write = 1'b1;
          // A cancelled dispatch (nothing pending at PUSH_H) jumps to 0000.
          if (sel_valid_q) begin
            pc_wdata = VECTOR_BASE + 16'(VECTOR_STRIDE * 32'(sel_q));
            for (int i = 0; i < NUM_IRQ; i++) begin
              if_clear[i] = (int'(sel_q) == i);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// ----------------------------------------------------------------------------
// tb_irq_dispatch_seq
//
// Directed bench for irq_dispatch_seq. Each cycle, all strobe outputs are
// packed into one vector and compared against a hand-computed value.
// ----------------------------------------------------------------------------
module tb_irq_dispatch_seq;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        instr_boundary;
  logic        ime;
  logic [4:0]  ie;
  logic [4:0]  if_in;
  logic [15:0] pc;
  logic        busy;
  logic        ime_clear;
  logic        halt_wake;
  logic        sp_dec;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic        pc_write;
  logic [15:0] pc_wdata;
  logic [4:0]  if_clear;

  int n_cmp;
  int n_bad;

  irq_dispatch_seq #(
    .NUM_IRQ      (5),
    .VECTOR_BASE  (16'h0040),
    .VECTOR_STRIDE(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .instr_boundary(instr_boundary),
    .ime           (ime),
    .ie            (ie),
    .if_in         (if_in),
    .pc            (pc),
    .busy          (busy),
    .ime_clear     (ime_clear),
    .halt_wake     (halt_wake),
    .sp_dec        (sp_dec),
    .mem_write     (mem_write),
    .mem_wdata     (mem_wdata),
    .pc_write      (pc_write),
    .pc_wdata      (pc_wdata),
    .if_clear      (if_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy, ime_clear, sp_dec, mem_write, mem_wdata, pc_write, pc_wdata, if_clear}
  logic [33:0] obs;
  assign obs = {busy, ime_clear, sp_dec, mem_write, mem_wdata, pc_write, pc_wdata, if_clear};

  function automatic logic [33:0] o(input logic b, input logic ic, input logic sp,
                                    input logic mw, input logic [7:0] wd, input logic pw,
                                    input logic [15:0] pwd, input logic [4:0] ifc);
    return {b, ic, sp, mw, wd, pw, pwd, ifc};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are driven 1 time unit after posedge, and
  // outputs are checked mid-cycle.
  task automatic cyc(input string tag, input logic en, input logic ib, input logic [33:0] exp);
    cpu_en         = en;
    instr_boundary = ib;
    #2;
    check(tag, {30'd0, obs}, {30'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // Full uninterrupted dispatch, followed by one idle cycle.
  task automatic dispatch(input string tag, input logic [15:0] pcv,
                          input logic [15:0] vec, input logic [4:0] ifc);
    pc = pcv;
    cyc({tag, "_start"}, 1'b1, 1'b1, o(1, 1, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc({tag, "_wait0"}, 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc({tag, "_wait1"}, 1'b1, 1'b0, o(1, 0, 1, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc({tag, "_push_h"}, 1'b1, 1'b0, o(1, 0, 1, 1, pcv[15:8], 0, 16'h0000, 5'h00));
    cyc({tag, "_push_l"}, 1'b1, 1'b0, o(1, 0, 0, 1, pcv[7:0], 0, 16'h0000, 5'h00));
    cyc({tag, "_jump"}, 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 1, vec, ifc));
    cyc({tag, "_idle"}, 1'b1, 1'b0, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    cpu_en         = 1'b1;
    instr_boundary = 1'b1;
    ime            = 1'b1;
    ie             = 5'h01;
    if_in          = 5'h01;
    pc             = 16'h1234;
    @(posedge clk);
    #1;

    // Reset: strobes are quiet and halt_wake still follows pending.
    cyc("rst", 1'b1, 1'b1, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    check("rst_halt_wake", {63'd0, halt_wake}, 64'd1);
    reset = 1'b0;
    cyc("rst_after", 1'b1, 1'b1, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));

    // Basic dispatch: bit 2 -> 0050
    ie    = 5'h04;
    if_in = 5'h04;
    dispatch("basic", 16'h1234, 16'h0050, 5'h04);

    // Priority: lowest set bit of 1F & 12 is bit 1 -> 0048
    ie    = 5'h1F;
    if_in = 5'h12;
    dispatch("prio1", 16'h0100, 16'h0048, 5'h02);
    if_in = 5'h10;
    dispatch("prio4", 16'h0200, 16'h0060, 5'h10);

    // Cancel: IE cleared during PUSH_H, so both pushes occur and the jump goes to 0000
    ie    = 5'h01;
    if_in = 5'h01;
    pc    = 16'hABCD;
    cyc("cancel_start", 1'b1, 1'b1, o(1, 1, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("cancel_wait0", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("cancel_wait1", 1'b1, 1'b0, o(1, 0, 1, 0, 8'h00, 0, 16'h0000, 5'h00));
    ie = 5'h00;
    cyc("cancel_push_h", 1'b1, 1'b0, o(1, 0, 1, 1, 8'hAB, 0, 16'h0000, 5'h00));
    cyc("cancel_push_l", 1'b1, 1'b0, o(1, 0, 0, 1, 8'hCD, 0, 16'h0000, 5'h00));
    cyc("cancel_jump", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 1, 16'h0000, 5'h00));
    check("cancel_halt_wake", {63'd0, halt_wake}, 64'd0);

    // IME gating: pending without IME -> no start, but halt_wake is set
    ie    = 5'h01;
    if_in = 5'h01;
    ime   = 1'b0;
    cyc("noime", 1'b1, 1'b1, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    check("noime_halt_wake", {63'd0, halt_wake}, 64'd1);

    // cpu_en gaps: the state holds and no strobes fire during a gap
    ime   = 1'b1;
    ie    = 5'h02;
    if_in = 5'h02;
    pc    = 16'h5678;
    cyc("gap_noen", 1'b0, 1'b1, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_start", 1'b1, 1'b1, o(1, 1, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_w0_hold", 1'b0, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_wait0", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_wait1", 1'b1, 1'b0, o(1, 0, 1, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_ph_hold0", 1'b0, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_ph_hold1", 1'b0, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_push_h", 1'b1, 1'b0, o(1, 0, 1, 1, 8'h56, 0, 16'h0000, 5'h00));
    cyc("gap_push_l", 1'b1, 1'b0, o(1, 0, 0, 1, 8'h78, 0, 16'h0000, 5'h00));
    cyc("gap_j_hold", 1'b0, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("gap_jump", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 1, 16'h0048, 5'h02));
    cyc("gap_idle", 1'b1, 1'b0, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));

    // Reset asserted in PUSH_L, then a clean dispatch afterwards
    ie    = 5'h04;
    if_in = 5'h04;
    pc    = 16'h1234;
    cyc("mrst_start", 1'b1, 1'b1, o(1, 1, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("mrst_wait0", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("mrst_wait1", 1'b1, 1'b0, o(1, 0, 1, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("mrst_push_h", 1'b1, 1'b0, o(1, 0, 1, 1, 8'h12, 0, 16'h0000, 5'h00));
    reset = 1'b1;
    cyc("mrst_in_pl", 1'b1, 1'b0, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    reset = 1'b0;
    cyc("mrst_after", 1'b1, 1'b1, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    dispatch("mrst_again", 16'h4321, 16'h0050, 5'h04);

    // Re-evaluation: a change in WAIT1 redirects the jump, a change after PUSH_H does not
    ie    = 5'h01;
    if_in = 5'h01;
    pc    = 16'h2000;
    cyc("reval_start", 1'b1, 1'b1, o(1, 1, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("reval_wait0", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));
    ie    = 5'h08;
    if_in = 5'h08;
    cyc("reval_wait1", 1'b1, 1'b0, o(1, 0, 1, 0, 8'h00, 0, 16'h0000, 5'h00));
    cyc("reval_push_h", 1'b1, 1'b0, o(1, 0, 1, 1, 8'h20, 0, 16'h0000, 5'h00));
    ie    = 5'h01;
    if_in = 5'h01;
    cyc("reval_push_l", 1'b1, 1'b0, o(1, 0, 0, 1, 8'h00, 0, 16'h0000, 5'h00));
    cyc("reval_jump", 1'b1, 1'b0, o(1, 0, 0, 0, 8'h00, 1, 16'h0058, 5'h08));
    cyc("reval_idle", 1'b1, 1'b0, o(0, 0, 0, 0, 8'h00, 0, 16'h0000, 5'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
